// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared size codes, state/owner encodings and byte-lane helpers
//               for the byte-serial memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam logic        c_true      = 1'b1;
    localparam logic        c_false     = 1'b0;
    localparam logic [31:0] c_zero_word = 32'h0000_0000;

    localparam logic [1:0]  c_size_byte = 2'b00;
    localparam logic [1:0]  c_size_half = 2'b01;
    localparam logic [1:0]  c_size_word = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Code 2'b10 is not a legal size and is handled as a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            c_size_byte: return 3'd1;
            c_size_half: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_if
// Description : Pipeline request/response and byte-RAM signals of mem_ctrl.
//               slave = controller side, master = pipeline and RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_done_o;
    logic [31:0]       if_data_o;

    logic              mem_r_req_i;
    logic              mem_w_req_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_w_data_i;
    logic [1:0]        mem_state_i;
    logic              mem_done_o;
    logic [31:0]       mem_r_data_o;

    logic [7:0]        ram_din_i;
    logic [7:0]        ram_dout_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_done_o, if_data_o,
        input  mem_r_req_i, mem_w_req_i, mem_addr_i, mem_w_data_i, mem_state_i,
        output mem_done_o, mem_r_data_o,
        input  ram_din_i,
        output ram_dout_o, ram_a_o, ram_wr_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_done_o, if_data_o,
        output mem_r_req_i, mem_w_req_i, mem_addr_i, mem_w_data_i, mem_state_i,
        input  mem_done_o, mem_r_data_o,
        output ram_din_i,
        input  ram_dout_o, ram_a_o, ram_wr_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Arbitrates IF and MEM requests onto one byte-wide synchronous
//               RAM port, serialising 1/2/4-byte accesses little-endian.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire        clk,
    input  wire        rst,
    mem_ctrl_if.slave  bus
);

    state_e            st_q,        st_d;
    owner_e            owner_q,     owner_d;
    logic [2:0]        cnt_q,       cnt_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [1:0]        size_q,      size_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [31:0]       asm_q,       asm_d;
    logic [31:0]       if_data_q,   if_data_d;
    logic [31:0]       mem_data_q,  mem_data_d;
    logic              if_done_q,   if_done_d;
    logic              mem_done_q,  mem_done_d;
    logic              ram_wr_q,    ram_wr_d;
    logic [ADDR_W-1:0] ram_a_q,     ram_a_d;
    logic [7:0]        ram_dout_q,  ram_dout_d;

    logic [2:0]        w_n_cur;
    logic [2:0]        w_n_nxt;

    always_comb begin
        st_d       = st_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        w_n_cur    = byte_count(size_q);

        case (st_q)
            ST_IDLE: begin
                if (bus.mem_w_req_i) begin
                    st_d    = ST_WRITE;
                    owner_d = OWN_MEM;
                    addr_d  = ADDR_W'(bus.mem_addr_i);
                    size_d  = bus.mem_state_i;
                    wdata_d = bus.mem_w_data_i;
                    cnt_d   = 3'd0;
                    asm_d   = c_zero_word;
                end else if (bus.mem_r_req_i) begin
                    st_d    = ST_READ;
                    owner_d = OWN_MEM;
                    addr_d  = ADDR_W'(bus.mem_addr_i);
                    size_d  = bus.mem_state_i;
                    wdata_d = bus.mem_w_data_i;
                    cnt_d   = 3'd0;
                    asm_d   = c_zero_word;
                end else if (bus.if_req_i) begin
                    st_d    = ST_READ;
                    owner_d = OWN_IF;
                    addr_d  = ADDR_W'(bus.if_addr_i);
                    size_d  = c_size_word;
                    wdata_d = c_zero_word;
                    cnt_d   = 3'd0;
                    asm_d   = c_zero_word;
                end
            end

            ST_READ: begin
                // A fetch whose requester has gone away is squashed silently.
                if (owner_q == OWN_IF && !bus.if_req_i) begin
                    st_d  = ST_IDLE;
                    cnt_d = 3'd0;
                end else begin
                    // RAM returns the byte addressed one cycle earlier.
                    if (cnt_q != 3'd0) begin
                        asm_d = set_byte(asm_q, 2'(cnt_q - 3'd1), bus.ram_din_i);
                    end
                    if (cnt_q == w_n_cur) begin
                        st_d = ST_DONE;
                        if (owner_q == OWN_IF) begin
                            if_data_d = asm_d;
                        end else begin
                            mem_data_d = asm_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_WRITE: begin
                if (cnt_q == 3'(w_n_cur - 3'd1)) begin
                    st_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            default: begin
                st_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_n_nxt    = byte_count(size_d);
        if_done_d  = (st_d == ST_DONE && owner_d == OWN_IF)  ? c_true : c_false;
        mem_done_d = (st_d == ST_DONE && owner_d == OWN_MEM) ? c_true : c_false;
        ram_wr_d   = (st_d == ST_WRITE) ? c_true : c_false;
        ram_a_d    = '0;
        ram_dout_d = 8'h00;
        if ((st_d == ST_READ && cnt_d < w_n_nxt) || st_d == ST_WRITE) begin
            ram_a_d = addr_d + ADDR_W'(cnt_d);
        end
        if (st_d == ST_WRITE) begin
            ram_dout_d = get_byte(wdata_d, cnt_d[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            owner_q    <= OWN_IF;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            size_q     <= c_size_byte;
            wdata_q    <= c_zero_word;
            asm_q      <= c_zero_word;
            if_data_q  <= c_zero_word;
            mem_data_q <= c_zero_word;
            if_done_q  <= c_false;
            mem_done_q <= c_false;
            ram_wr_q   <= c_false;
            ram_a_q    <= '0;
            ram_dout_q <= 8'h00;
        end else begin
            st_q       <= st_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
            ram_wr_q   <= ram_wr_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
        end
    end

    assign bus.if_done_o    = if_done_q;
    assign bus.if_data_o    = if_data_q;
    assign bus.mem_done_o   = mem_done_q;
    assign bus.mem_r_data_o = mem_data_q;
    assign bus.ram_wr_o     = ram_wr_q;
    assign bus.ram_a_o      = ram_a_q;
    assign bus.ram_dout_o   = ram_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a byte RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [7:0] ram_mem [0:65535];

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        bus.ram_din_i <= ram_mem[bus.ram_a_o[15:0]];
        if (bus.ram_wr_o) begin
            ram_mem[bus.ram_a_o[15:0]] <= bus.ram_dout_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = 32'h0;
        bus.mem_r_req_i  = 1'b0;
        bus.mem_w_req_i  = 1'b0;
        bus.mem_addr_i   = 32'h0;
        bus.mem_w_data_i = 32'h0;
        bus.mem_state_i  = 2'b00;

        ram_mem[16'h0100] <= 8'h13; ram_mem[16'h0101] <= 8'h05;
        ram_mem[16'h0102] <= 8'h00; ram_mem[16'h0103] <= 8'h00;
        ram_mem[16'h0040] <= 8'h80; ram_mem[16'h0041] <= 8'hFF;
        ram_mem[16'h0010] <= 8'h11; ram_mem[16'h0011] <= 8'h22;
        ram_mem[16'h0012] <= 8'h33; ram_mem[16'h0013] <= 8'h44;
        ram_mem[16'h0300] <= 8'hAA; ram_mem[16'h0301] <= 8'hBB;
        ram_mem[16'h0302] <= 8'hCC; ram_mem[16'h0303] <= 8'hDD;

        tick();
        tick();
        chk("rst_if_done",  bus.if_done_o,    0);
        chk("rst_mem_done", bus.mem_done_o,   0);
        chk("rst_ram_wr",   bus.ram_wr_o,     0);
        chk("rst_ram_a",    bus.ram_a_o,      0);
        chk("rst_ram_dout", bus.ram_dout_o,   0);
        chk("rst_if_data",  bus.if_data_o,    0);
        chk("rst_mem_data", bus.mem_r_data_o, 0);
        rst = 1'b0;
        tick();

        // IF word fetch at 0x100
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk("if_rd_ram_a", bus.ram_a_o, (c <= 4) ? 32'h100 + c - 1 : 32'h0);
            chk("if_rd_wr",    bus.ram_wr_o, 0);
            chk("if_rd_done",  bus.if_done_o, (c == 6));
            chk("if_rd_mdone", bus.mem_done_o, 0);
            if (c == 6) begin
                chk("if_rd_data", bus.if_data_o, 32'h0000_0513);
                bus.if_req_i = 1'b0;
            end
        end

        // MEM store half 0x2002
        bus.mem_w_req_i  = 1'b1;
        bus.mem_addr_i   = 32'h0000_2002;
        bus.mem_w_data_i = 32'hDEAD_BEEF;
        bus.mem_state_i  = 2'b01;
        tick();
        chk("sh_c1_wr",   bus.ram_wr_o,   1);
        chk("sh_c1_a",    bus.ram_a_o,    32'h2002);
        chk("sh_c1_dout", bus.ram_dout_o, 8'hEF);
        chk("sh_c1_done", bus.mem_done_o, 0);
        tick();
        chk("sh_c2_wr",   bus.ram_wr_o,   1);
        chk("sh_c2_a",    bus.ram_a_o,    32'h2003);
        chk("sh_c2_dout", bus.ram_dout_o, 8'hBE);
        chk("sh_c2_done", bus.mem_done_o, 0);
        tick();
        chk("sh_c3_wr",   bus.ram_wr_o,   0);
        chk("sh_c3_a",    bus.ram_a_o,    0);
        chk("sh_c3_done", bus.mem_done_o, 1);
        bus.mem_w_req_i = 1'b0;
        tick();
        chk("sh_c4_done", bus.mem_done_o, 0);
        chk("sh_ram_lo",  ram_mem[16'h2002], 8'hEF);
        chk("sh_ram_hi",  ram_mem[16'h2003], 8'hBE);

        // MEM load byte at 0x40
        bus.mem_r_req_i = 1'b1;
        bus.mem_addr_i  = 32'h0000_0040;
        bus.mem_state_i = 2'b00;
        tick();
        chk("lb_c1_a",    bus.ram_a_o,    32'h40);
        chk("lb_c1_done", bus.mem_done_o, 0);
        tick();
        chk("lb_c2_a",    bus.ram_a_o,    0);
        chk("lb_c2_done", bus.mem_done_o, 0);
        tick();
        chk("lb_c3_done", bus.mem_done_o,   1);
        chk("lb_c3_data", bus.mem_r_data_o, 32'h0000_0080);
        bus.mem_r_req_i = 1'b0;
        tick();

        // Simultaneous IF fetch 0x300 and MEM load word 0x10
        bus.mem_r_req_i = 1'b1;
        bus.mem_addr_i  = 32'h0000_0010;
        bus.mem_state_i = 2'b11;
        bus.if_req_i    = 1'b1;
        bus.if_addr_i   = 32'h0000_0300;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk("arb_mem_done", bus.mem_done_o, (c == 6));
            chk("arb_if_done",  bus.if_done_o,  (c == 13));
            if (c == 1) begin
                chk("arb_c1_a",     bus.ram_a_o,   32'h10);
                chk("arb_if_held",  bus.if_data_o, 32'h0000_0513);
            end
            if (c == 6) begin
                chk("arb_mem_data", bus.mem_r_data_o, 32'h4433_2211);
                bus.mem_r_req_i = 1'b0;
            end
            if (c == 7) chk("arb_c7_a", bus.ram_a_o, 0);
            if (c == 8) chk("arb_c8_a", bus.ram_a_o, 32'h300);
            if (c == 13) begin
                chk("arb_if_data", bus.if_data_o, 32'hDDCC_BBAA);
                bus.if_req_i = 1'b0;
            end
        end

        // IF fetch at 0x200 squashed in cycle 3, then MEM store byte
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0200;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("abt_ram_a",   bus.ram_a_o, (c <= 3) ? 32'h200 + c - 1 : 32'h0);
            chk("abt_if_done", bus.if_done_o, 0);
            if (c == 3) bus.if_req_i = 1'b0;
        end
        bus.mem_w_req_i  = 1'b1;
        bus.mem_addr_i   = 32'h0000_0500;
        bus.mem_w_data_i = 32'hCAFE_F05A;
        bus.mem_state_i  = 2'b00;
        tick();
        chk("sb_c1_wr",   bus.ram_wr_o,   1);
        chk("sb_c1_a",    bus.ram_a_o,    32'h500);
        chk("sb_c1_dout", bus.ram_dout_o, 8'h5A);
        tick();
        chk("sb_c2_done", bus.mem_done_o, 1);
        chk("sb_c2_wr",   bus.ram_wr_o,   0);
        chk("sb_c2_ifd",  bus.if_done_o,  0);
        bus.mem_w_req_i = 1'b0;
        tick();
        chk("sb_c3_done", bus.mem_done_o, 0);
        chk("sb_ram",     ram_mem[16'h0500], 8'h5A);
        chk("abt_if_data_held", bus.if_data_o, 32'hDDCC_BBAA);

        // MEM store word at 0x600 interrupted by reset in cycle 2
        bus.mem_w_req_i  = 1'b1;
        bus.mem_addr_i   = 32'h0000_0600;
        bus.mem_w_data_i = 32'h1234_5678;
        bus.mem_state_i  = 2'b11;
        tick();
        chk("sw_c1_a",    bus.ram_a_o,    32'h600);
        chk("sw_c1_dout", bus.ram_dout_o, 8'h78);
        tick();
        chk("sw_c2_wr",   bus.ram_wr_o,   1);
        chk("sw_c2_a",    bus.ram_a_o,    32'h601);
        chk("sw_c2_dout", bus.ram_dout_o, 8'h56);
        rst = 1'b1;
        tick();
        chk("swr_wr",       bus.ram_wr_o,     0);
        chk("swr_a",        bus.ram_a_o,      0);
        chk("swr_dout",     bus.ram_dout_o,   0);
        chk("swr_mem_done", bus.mem_done_o,   0);
        chk("swr_if_done",  bus.if_done_o,    0);
        chk("swr_if_data",  bus.if_data_o,    0);
        chk("swr_mem_data", bus.mem_r_data_o, 0);
        rst             = 1'b0;
        bus.mem_w_req_i = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            tick();
            chk("swr_idle_wr",   bus.ram_wr_o,   0);
            chk("swr_idle_done", bus.mem_done_o, 0);
        end

        // Load back the byte that was written before the reset
        bus.mem_r_req_i = 1'b1;
        bus.mem_addr_i  = 32'h0000_0600;
        bus.mem_state_i = 2'b00;
        tick();
        chk("lb2_c1_a", bus.ram_a_o, 32'h600);
        tick();
        chk("lb2_c2_done", bus.mem_done_o, 0);
        tick();
        chk("lb2_c3_done", bus.mem_done_o,   1);
        chk("lb2_c3_data", bus.mem_r_data_o, 32'h0000_0078);
        bus.mem_r_req_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
